cache_fill_ctrl: RTL and testbench

Miss-handling controller for one cache (instantiated once for I-cache and once for D-cache) in the phase-3 WISC pipeline. It classifies each lookup as hit or miss and drives the per-access cache_req/cache_hit strobes that the CPU stats/trace monitor counts. On a miss it stalls the pipeline, issues pipelined word reads for the whole block to the multi-cycle main memory, writes the returned words into the data array, then writes the tag.

---
 rtl/wisc_cache_pkg.sv | 21 ++
 rtl/fill_counter.sv | 24 ++
 rtl/cache_fill_ctrl.sv | 99 +++++++++
 tb/tb_cache_fill_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/wisc_cache_pkg.sv
// rtl/wisc_cache_pkg.sv - shared cache geometry, fill-state enum and block-address helper
package wisc_cache_pkg;

  localparam int ADDR_WIDTH    = 16;
  localparam int BLOCK_WORDS   = 8;
  localparam int MEM_LAT       = 4;
  localparam int OFFSET_BITS   = $clog2(2 * BLOCK_WORDS);
  localparam int WORD_IDX_BITS = $clog2(BLOCK_WORDS);
  // Counters must reach BLOCK_WORDS itself, hence one extra bit.
  localparam int CNT_BITS      = WORD_IDX_BITS + 1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  function automatic logic [ADDR_WIDTH-1:0] block_base(input logic [ADDR_WIDTH-1:0] addr);
    return addr & ~ADDR_WIDTH'((1 << OFFSET_BITS) - 1);
  endfunction

endpackage

// File: rtl/fill_counter.sv
// rtl/fill_counter.sv - clearable enabled up-counter that saturates at a terminal count
module fill_counter #(
  parameter int WIDTH    = 4,
  parameter int TERMINAL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  assign done = (count == WIDTH'(TERMINAL));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !done) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - cache miss classifier and block-fill sequencer to main memory
module cache_fill_ctrl
  import wisc_cache_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lookup_valid,
  input  logic                     lookup_hit,
  input  logic [ADDR_WIDTH-1:0]    lookup_addr,
  output logic                     fsm_busy,
  output logic                     mem_rd_en,
  output logic [ADDR_WIDTH-1:0]    mem_address,
  input  logic                     mem_data_valid,
  input  logic [ADDR_WIDTH-1:0]    mem_data,
  output logic                     write_data_array,
  output logic [WORD_IDX_BITS-1:0] fill_word_index,
  output logic [ADDR_WIDTH-1:0]    fill_data,
  output logic                     write_tag_array,
  output logic                     cache_req,
  output logic                     cache_hit
);

  fill_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CNT_BITS-1:0]   issue_cnt, recv_cnt;
  logic issue_done, recv_done;
  logic in_idle, in_fill, req_w, miss, issue_active, recv_fire, recv_last;

  // Everything is gated by rst so outputs read 0 throughout the reset cycle.
  assign in_idle      = !rst && (state_q == IDLE);
  assign in_fill      = !rst && (state_q == FILL);
  assign req_w        = lookup_valid && in_idle;
  assign miss         = req_w && !lookup_hit;
  assign issue_active = in_fill && !issue_done;
  assign recv_fire    = in_fill && mem_data_valid && !recv_done;
  assign recv_last    = recv_fire && (recv_cnt == CNT_BITS'(BLOCK_WORDS - 1));

  fill_counter #(.WIDTH(CNT_BITS), .TERMINAL(BLOCK_WORDS)) u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (miss),
    .en    (issue_active),
    .count (issue_cnt),
    .done  (issue_done)
  );

  fill_counter #(.WIDTH(CNT_BITS), .TERMINAL(BLOCK_WORDS)) u_recv_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (miss),
    .en    (recv_fire),
    .count (recv_cnt),
    .done  (recv_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      if (miss) begin
        base_q <= block_base(lookup_addr);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss)      state_d = FILL;
      FILL:    if (recv_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cache_req        = req_w;
    cache_hit        = req_w && lookup_hit;
    fsm_busy         = in_fill || miss;
    mem_rd_en        = 1'b0;
    mem_address      = '0;
    write_data_array = 1'b0;
    fill_word_index  = '0;
    fill_data        = '0;
    write_tag_array  = 1'b0;
    if (issue_active) begin
      mem_rd_en   = 1'b1;
      mem_address = base_q + ADDR_WIDTH'({issue_cnt, 1'b0});
    end
    if (recv_fire) begin
      write_data_array = 1'b1;
      fill_word_index  = recv_cnt[WORD_IDX_BITS-1:0];
      fill_data        = mem_data;
      write_tag_array  = recv_last;
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb/tb_cache_fill_ctrl.sv - vector, directed and randomized checks of cache_fill_ctrl
module tb_cache_fill_ctrl;
  import wisc_cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lookup_valid = 1'b0, lookup_hit = 1'b0;
  logic [15:0] lookup_addr = '0;
  logic        fsm_busy, mem_rd_en;
  logic [15:0] mem_address;
  logic        mem_data_valid = 1'b0;
  logic [15:0] mem_data = '0;
  logic        write_data_array;
  logic [2:0]  fill_word_index;
  logic [15:0] fill_data;
  logic        write_tag_array, cache_req, cache_hit;

  cache_fill_ctrl dut (
    .clk(clk), .rst(rst), .lookup_valid(lookup_valid), .lookup_hit(lookup_hit),
    .lookup_addr(lookup_addr), .fsm_busy(fsm_busy), .mem_rd_en(mem_rd_en),
    .mem_address(mem_address), .mem_data_valid(mem_data_valid), .mem_data(mem_data),
    .write_data_array(write_data_array), .fill_word_index(fill_word_index),
    .fill_data(fill_data), .write_tag_array(write_tag_array),
    .cache_req(cache_req), .cache_hit(cache_hit)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;

  typedef struct { int due; logic [15:0] data; } ret_t;
  ret_t memq[$];
  bit   dir_mode = 0;
  int   dir_cnt = 0;

  // Reference model: a fill is described by its start cycle, block base and returns seen.
  bit          m_fill = 0;
  int          m_start = 0, m_recv = 0;
  logic [15:0] m_base = '0;

  logic s_req, s_hit, s_busy, s_rd, s_wr, s_tag;
  logic [15:0] s_addr, s_data;
  logic [2:0]  s_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic lv, input logic lh, input logic [15:0] a,
                      input logic r, input logic stray);
    logic e_req, e_hit, e_busy, e_rd, e_wr, e_tag;
    logic [15:0] e_addr, e_data;
    int k;
    @(posedge clk); #1;
    rst = r; lookup_valid = lv; lookup_hit = lh; lookup_addr = a;
    mem_data_valid = 1'b0; mem_data = '0;
    if (memq.size() > 0 && memq[0].due == cyc) begin
      mem_data_valid = 1'b1;
      mem_data = memq[0].data;
      void'(memq.pop_front());
    end else if (stray) begin
      mem_data_valid = 1'b1;
      mem_data = 16'($urandom);
    end
    @(negedge clk);
    s_req = cache_req; s_hit = cache_hit; s_busy = fsm_busy; s_rd = mem_rd_en;
    s_addr = mem_address; s_wr = write_data_array; s_idx = fill_word_index;
    s_data = fill_data; s_tag = write_tag_array;

    k = cyc - m_start;
    e_req  = !r && lv && !m_fill;
    e_hit  = e_req && lh;
    e_busy = !r && (m_fill || (e_req && !lh));
    e_rd   = !r && m_fill && k >= 1 && k <= BLOCK_WORDS;
    e_addr = e_rd ? 16'(m_base + 2 * (k - 1)) : 16'h0;
    e_wr   = !r && m_fill && mem_data_valid;
    e_data = e_wr ? mem_data : 16'h0;
    e_tag  = e_wr && (m_recv == BLOCK_WORDS - 1);
    chk("cache_req", 32'(s_req), 32'(e_req));
    chk("cache_hit", 32'(s_hit), 32'(e_hit));
    chk("fsm_busy", 32'(s_busy), 32'(e_busy));
    chk("mem_rd_en", 32'(s_rd), 32'(e_rd));
    chk("mem_address", 32'(s_addr), 32'(e_addr));
    chk("write_data_array", 32'(s_wr), 32'(e_wr));
    chk("fill_word_index", 32'(s_idx), e_wr ? 32'(m_recv) : 32'h0);
    chk("fill_data", 32'(s_data), 32'(e_data));
    chk("write_tag_array", 32'(s_tag), 32'(e_tag));

    if (r) begin
      m_fill = 0; m_recv = 0;
    end else if (e_req && !lh) begin
      m_fill = 1; m_start = cyc; m_recv = 0; m_base = a & 16'hFFF0;
    end else if (e_wr) begin
      m_recv++;
      if (m_recv == BLOCK_WORDS) m_fill = 0;
    end

    if (mem_rd_en) begin
      memq.push_back('{due: cyc + MEM_LAT,
                       data: dir_mode ? 16'(16'hA000 + dir_cnt) : 16'($urandom)});
      if (dir_mode) dir_cnt++;
    end
    cyc++;
  endtask

  typedef struct {
    logic lv, lh; logic [15:0] addr; logic stray;
    logic exp_req, exp_hit, exp_busy, exp_wr;
  } vec_t;
  vec_t vecs[6];

  int reqs, hits;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 16'h0040, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 16'hFFFE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("idle_busy", 32'(s_busy), 32'h0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("stray_wr", 32'(s_wr), 32'h0);

    foreach (vecs[i]) begin
      step(vecs[i].lv, vecs[i].lh, vecs[i].addr, 1'b0, vecs[i].stray);
      chk("vec_req", 32'(s_req), 32'(vecs[i].exp_req));
      chk("vec_hit", 32'(s_hit), 32'(vecs[i].exp_hit));
      chk("vec_busy", 32'(s_busy), 32'(vecs[i].exp_busy));
      chk("vec_wr", 32'(s_wr), 32'(vecs[i].exp_wr));
      chk("vec_rd", 32'(s_rd), 32'h0);
    end

    // Miss at 0x1236 with 0xA000+i returns, lookups pulsed during the fill, retry hit at T+13.
    dir_mode = 1; dir_cnt = 0; reqs = 0; hits = 0;
    step(1'b1, 1'b0, 16'h1236, 1'b0, 1'b0);
    reqs += s_req; hits += s_hit;
    chk("miss_busy", 32'(s_busy), 32'h1);
    for (int k = 1; k <= 13; k++) begin
      step(k == 13 ? 1'b1 : 1'(k % 2), 1'b1, 16'h1236, 1'b0, 1'b0);
      reqs += s_req; hits += s_hit;
      chk("fill_rd", 32'(s_rd), 32'(k <= 8));
      if (k <= 8) chk("fill_addr", 32'(s_addr), 32'(16'h1230 + 2 * (k - 1)));
      chk("fill_wr", 32'(s_wr), 32'(k >= 5 && k <= 12));
      if (k >= 5 && k <= 12) begin
        chk("fill_idx", 32'(s_idx), 32'(k - 5));
        chk("fill_data_a", 32'(s_data), 32'(16'hA000 + k - 5));
      end
      chk("fill_tag", 32'(s_tag), 32'(k == 12));
      chk("fill_busy", 32'(s_busy), 32'(k <= 12));
    end
    chk("retry_reqs", 32'(reqs), 32'd2);
    chk("retry_hits", 32'(hits), 32'd1);
    dir_mode = 0;

    // Reset at T+6 of a fill, late returns ignored, then a fill at the top of memory.
    step(1'b1, 1'b0, 16'h2000, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b0, 16'h0, k == 6, 1'b0);
      chk("rst_tag", 32'(s_tag), 32'h0);
      if (k >= 7) chk("late_wr", 32'(s_wr), 32'h0);
      if (k >= 7) chk("late_busy", 32'(s_busy), 32'h0);
    end
    step(1'b1, 1'b0, 16'hFFF8, 1'b0, 1'b0);
    for (int k = 1; k <= 13; k++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      if (k <= 8) chk("wrap_addr", 32'(s_addr), 32'(16'hFFF0 + 2 * (k - 1)));
      chk("wrap_tag", 32'(s_tag), 32'(k == 12));
    end

    // Back-to-back: miss in the first IDLE cycle after a fill.
    step(1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0210, 1'b0, 1'b0);
    chk("b2b_busy", 32'(s_busy), 32'h1);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("b2b_addr", 32'(s_addr), 32'h0210);

    for (int n = 0; n < 1500; n++) begin
      step(1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 6), 16'($urandom),
           1'($urandom_range(0, 199) == 0), !m_fill && $urandom_range(0, 9) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
